// File: rtl/dpc_counter_pkg.sv
// rtl/dpc_counter_pkg.sv - shared types and digit stepping helper for the ripple counter
package dpc_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  typedef struct packed {
    logic               wrap;
    logic [DIGIT_W-1:0] value;
  } digit_res_t;

  // One ring step of a single digit; wrap flags the hand-off to the next digit.
  function automatic digit_res_t digit_next(input logic [DIGIT_W-1:0] value,
                                            input logic dec,
                                            input logic [DIGIT_W:0] radix);
    digit_res_t         res;
    logic [DIGIT_W-1:0] top;
    top = DIGIT_W'(radix - 1'b1);
    if (dec) begin
      res.wrap  = (value == '0);
      res.value = res.wrap ? top : value - 1'b1;
    end else begin
      res.wrap  = (value == top);
      res.value = res.wrap ? '0 : value + 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - 4-bit wrap counter with runtime top, clear and terminal count
module step_timer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] top,
  output logic       tc
);

  logic [3:0] value;

  assign tc = (value == top);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= tc ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/dekatron_ripple_counter.sv
// rtl/dekatron_ripple_counter.sv - multi-digit ring counter with digit-by-digit ripple stepping
module dekatron_ripple_counter
  import dpc_counter_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int RADIX       = 10,
  parameter int STEP_CYCLES = 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Request,
  input  logic                      Dec,
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] LoadValue,
  input  logic                      Clear,
  output logic                      Ready,
  output logic [DIGIT_W*DIGITS-1:0] Count,
  output logic                      Zero,
  output logic                      Carry
);

  localparam int D_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW  = DIGIT_W * DIGITS;

  state_t             state, state_next;
  logic [D_W-1:0]     d;
  logic               dec_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      load_clamped;
  logic               carry_q;
  logic               timer_tc;
  logic [DIGIT_W-1:0] cur_digit;
  digit_res_t         step_res;
  logic               last_digit;

  step_timer u_timer (
    .Clk (Clk),
    .Rst (Rst),
    .clr (Clear || (state != STEP)),
    .en  (state == STEP),
    .top (4'(STEP_CYCLES - 1)),
    .tc  (timer_tc)
  );

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d == D_W'(i)) cur_digit = count_q[i*DIGIT_W +: DIGIT_W];
    end
    step_res   = digit_next(cur_digit, dec_q, (DIGIT_W+1)'(RADIX));
    last_digit = (d == D_W'(DIGITS - 1));
  end

  // Out-of-range load digits saturate to the top ring state.
  always_comb begin
    load_clamped = LoadValue;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, LoadValue[i*DIGIT_W +: DIGIT_W]} >= (DIGIT_W+1)'(RADIX))
        load_clamped[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(RADIX - 1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Request && !Load) state_next = STEP;
      STEP:    if (timer_tc && (!step_res.wrap || last_digit)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (Clear) state_next = IDLE;
  end

  always_comb begin
    Ready = (state == IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q <= '0;
      d       <= '0;
      dec_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      if (Clear) begin
        count_q <= '0;
        d       <= '0;
      end else begin
        case (state)
          IDLE: if (Request) begin
            dec_q <= Dec;
            d     <= '0;
            if (Load) count_q <= load_clamped;
          end
          STEP: if (timer_tc) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (d == D_W'(i)) count_q[i*DIGIT_W +: DIGIT_W] <= step_res.value;
            end
            if (step_res.wrap) begin
              if (last_digit) carry_q <= 1'b1;
              else            d <= d + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Count = count_q;
  assign Carry = carry_q;
  assign Zero  = (count_q == '0);

endmodule

// File: tb/tb_dekatron_ripple_counter.sv
// tb/tb_dekatron_ripple_counter.sv - directed self-checking bench for dekatron_ripple_counter
module tb_dekatron_ripple_counter;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic        a_req = 0, a_dec = 0, a_load = 0, a_clr = 0;
  logic [11:0] a_lv = '0;
  logic        a_ready, a_zero, a_carry;
  logic [11:0] a_count;

  logic        b_req = 0, b_dec = 0, b_load = 0, b_clr = 0;
  logic [15:0] b_lv = '0;
  logic        b_ready, b_zero, b_carry;
  logic [15:0] b_count;

  logic        c_req = 0, c_dec = 0, c_load = 0, c_clr = 0;
  logic [11:0] c_lv = '0;
  logic        c_ready, c_zero, c_carry;
  logic [11:0] c_count;

  int total  = 0;
  int passed = 0;

  dekatron_ripple_counter #(.DIGITS(3), .RADIX(10), .STEP_CYCLES(2)) u_a (
    .Clk(Clk), .Rst(Rst), .Request(a_req), .Dec(a_dec), .Load(a_load),
    .LoadValue(a_lv), .Clear(a_clr), .Ready(a_ready), .Count(a_count),
    .Zero(a_zero), .Carry(a_carry));

  dekatron_ripple_counter #(.DIGITS(4), .RADIX(2), .STEP_CYCLES(2)) u_b (
    .Clk(Clk), .Rst(Rst), .Request(b_req), .Dec(b_dec), .Load(b_load),
    .LoadValue(b_lv), .Clear(b_clr), .Ready(b_ready), .Count(b_count),
    .Zero(b_zero), .Carry(b_carry));

  dekatron_ripple_counter #(.DIGITS(3), .RADIX(10), .STEP_CYCLES(1)) u_c (
    .Clk(Clk), .Rst(Rst), .Request(c_req), .Dec(c_dec), .Load(c_load),
    .LoadValue(c_lv), .Clear(c_clr), .Ready(c_ready), .Count(c_count),
    .Zero(c_zero), .Carry(c_carry));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic a_chk(input string tag, input logic [11:0] cnt, input logic rdy, input logic cry);
    chk({tag, ".count"}, 16'(a_count), 16'(cnt));
    chk({tag, ".ready"}, 16'(a_ready), 16'(rdy));
    chk({tag, ".carry"}, 16'(a_carry), 16'(cry));
  endtask

  task automatic a_do_load(input logic [11:0] v);
    a_req = 1; a_load = 1; a_lv = v;
    tick();
    a_req = 0; a_load = 0;
  endtask

  task automatic a_start(input logic dec);
    a_req = 1; a_dec = dec;
    tick();
    a_req = 0;
  endtask

  initial begin
    // Reset values while Rst is held
    #2;
    a_chk("rst", 12'h000, 1, 0);
    chk("rst.zero", 16'(a_zero), 16'd1);
    @(posedge Clk); #1;
    Rst = 0;

    // Single increment from 000
    a_start(0);             a_chk("inc1.e0", 12'h000, 0, 0);
    tick();                 a_chk("inc1.e1", 12'h000, 0, 0);
    tick();                 a_chk("inc1.e2", 12'h001, 0, 0);
    tick();                 a_chk("inc1.e3", 12'h001, 1, 0);
    chk("inc1.zero", 16'(a_zero), 16'd0);

    // 099 + 1 ripples through two wraps
    a_do_load(12'h099);     a_chk("ld099", 12'h099, 1, 0);
    a_start(0);             a_chk("r099.e0", 12'h099, 0, 0);
    tick();                 a_chk("r099.e1", 12'h099, 0, 0);
    tick();                 a_chk("r099.e2", 12'h090, 0, 0);
    tick();                 a_chk("r099.e3", 12'h090, 0, 0);
    tick();                 a_chk("r099.e4", 12'h000, 0, 0);
    tick();                 a_chk("r099.e5", 12'h000, 0, 0);
    tick();                 a_chk("r099.e6", 12'h100, 0, 0);
    tick();                 a_chk("r099.e7", 12'h100, 1, 0);

    // 999 + 1 overflows with a one-cycle Carry
    a_do_load(12'h999);
    a_start(0);
    tick(); tick();         a_chk("ov.e2", 12'h990, 0, 0);
    tick(); tick();         a_chk("ov.e4", 12'h900, 0, 0);
    tick();                 a_chk("ov.e5", 12'h900, 0, 0);
    tick();                 a_chk("ov.e6", 12'h000, 0, 1);
    tick();                 a_chk("ov.e7", 12'h000, 1, 0);
    chk("ov.zero", 16'(a_zero), 16'd1);

    // 000 - 1 underflows with a one-cycle Carry
    a_do_load(12'h000);
    a_start(1);
    tick(); tick();         a_chk("un.e2", 12'h009, 0, 0);
    tick(); tick();         a_chk("un.e4", 12'h099, 0, 0);
    tick(); tick();         a_chk("un.e6", 12'h999, 0, 1);
    tick();                 a_chk("un.e7", 12'h999, 1, 0);
    chk("un.zero", 16'(a_zero), 16'd0);

    // Load clamp: A,F,3 -> 9,9,3
    a_do_load(12'hAF3);     a_chk("clamp", 12'h993, 1, 0);

    // Request held through STEP and DONE is taken once only
    a_req = 1; a_dec = 0;
    tick();                 a_chk("hold.e0", 12'h993, 0, 0);
    tick();
    tick();                 a_chk("hold.e2", 12'h994, 0, 0);
    tick();                 a_chk("hold.e3", 12'h994, 1, 0);
    a_req = 0;
    tick();                 a_chk("hold.e4", 12'h994, 1, 0);

    // Clear at edge 3 of a 099 increment
    a_do_load(12'h099);
    a_start(0);
    tick(); tick();         a_chk("clr.e2", 12'h090, 0, 0);
    a_clr = 1;
    tick();                 a_chk("clr.e3", 12'h000, 1, 0);
    a_clr = 0;
    tick();                 a_chk("clr.e4", 12'h000, 1, 0);

    // RADIX=2, DIGITS=4: 0000 - 1 -> 1111
    b_req = 1; b_load = 1; b_lv = 16'h0000;
    tick();
    b_load = 0; b_dec = 1;
    tick();
    b_req = 0;
    chk("b.e0.ready", 16'(b_ready), 16'd0);
    tick(); tick();         chk("b.e2", b_count, 16'h0001);
    tick(); tick();         chk("b.e4", b_count, 16'h0011);
    tick(); tick();         chk("b.e6", b_count, 16'h0111);
    tick(); tick();         chk("b.e8", b_count, 16'h1111);
    chk("b.e8.carry", 16'(b_carry), 16'd1);
    tick();                 chk("b.e9.ready", 16'(b_ready), 16'd1);
    chk("b.e9.carry", 16'(b_carry), 16'd0);

    // Asynchronous Rst in the middle of a ripple
    a_do_load(12'h999);
    a_start(0);
    tick(); tick();         a_chk("arst.e2", 12'h990, 0, 0);
    tick();
    #2;
    Rst = 1;
    #1;
    a_chk("arst.now", 12'h000, 1, 0);
    chk("arst.zero", 16'(a_zero), 16'd1);
    Rst = 0;
    tick();                 a_chk("arst.next", 12'h000, 1, 0);

    // STEP_CYCLES=1: Ready low for exactly two cycles
    chk("c.pre.ready", 16'(c_ready), 16'd1);
    c_req = 1; c_dec = 0;
    tick();
    c_req = 0;
    chk("c.e0.ready", 16'(c_ready), 16'd0);
    tick();
    chk("c.e1.ready", 16'(c_ready), 16'd0);
    chk("c.e1.count", 16'(c_count), 16'h0001);
    tick();
    chk("c.e2.ready", 16'(c_ready), 16'd1);
    chk("c.e2.count", 16'(c_count), 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
